// File: rtl/microseq_next_state_if.sv
// Sequencer bus: microinstruction/condition inputs toward the sequencer,
// registered state, next state and stack status back out.
interface microseq_next_state_if #(
  parameter int ADDR_W      = 7,
  parameter int NCOND       = 4,
  parameter int CSEL_W      = 2,
  parameter int STACK_DEPTH = 4
);
  localparam int SP_W = $clog2(STACK_DEPTH + 1);

  logic              en;
  logic [3:0]        n;
  logic [CSEL_W-1:0] s;
  logic              inv;
  logic [NCOND-1:0]  conds;
  logic [ADDR_W-1:0] enc_addr;
  logic [ADDR_W-1:0] cr;
  logic [ADDR_W-1:0] state;
  logic [ADDR_W-1:0] next_state;
  logic [SP_W-1:0]   sp;
  logic              stk_ovf;
  logic              stk_udf;

  modport master (
    output en, n, s, inv, conds, enc_addr, cr,
    input  state, next_state, sp, stk_ovf, stk_udf
  );

  modport slave (
    input  en, n, s, inv, conds, enc_addr, cr,
    output state, next_state, sp, stk_ovf, stk_udf
  );
endinterface

// File: rtl/microseq_next_state.sv
// Microprogram sequencer: registered control-store state, next-state mux
// and a return-address stack for micro-subroutines. Updates on falling edge.
module microseq_next_state #(
  parameter int ADDR_W      = 7,
  parameter int NCOND       = 4,
  parameter int CSEL_W      = 2,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_ADDR  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  microseq_next_state_if.slave bus
);
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] RST_VEC = ADDR_W'(RESET_ADDR);

  localparam logic [3:0] M_ENC   = 4'd0;
  localparam logic [3:0] M_VEC   = 4'd1;
  localparam logic [3:0] M_JMP   = 4'd2;
  localparam logic [3:0] M_INC   = 4'd3;
  localparam logic [3:0] M_EC    = 4'd4;
  localparam logic [3:0] M_VC    = 4'd5;
  localparam logic [3:0] M_IV    = 4'd6;
  localparam logic [3:0] M_IC    = 4'd7;
  localparam logic [3:0] M_CALL  = 4'd8;
  localparam logic [3:0] M_RET   = 4'd9;
  localparam logic [3:0] M_CCALL = 4'd10;
  localparam logic [3:0] M_CRET  = 4'd11;
  localparam logic [3:0] M_WAIT  = 4'd12;

  logic [ADDR_W-1:0]                   state_q, nxt, inc, top;
  logic [SP_W-1:0]                     sp_q, sp_m1;
  logic [STACK_DEPTH-1:0][ADDR_W-1:0]  stk_q;
  logic                                ovf_q, udf_q;
  logic                                sts, push, pop, full, empty;
  logic [2**CSEL_W-1:0]                cond_pad;

  // Unimplemented select codes read as a false condition before inversion.
  always_comb begin
    cond_pad             = '0;
    cond_pad[NCOND-1:0]  = bus.conds;
  end

  assign sts   = cond_pad[bus.s] ^ bus.inv;
  assign inc   = state_q + ADDR_W'(1);
  assign empty = (sp_q == '0);
  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign sp_m1 = sp_q - SP_W'(1);
  assign top   = empty ? RST_VEC : stk_q[sp_m1[IDX_W-1:0]];

  always_comb begin
    nxt  = inc;
    push = 1'b0;
    pop  = 1'b0;
    unique case (bus.n)
      M_ENC:   nxt = bus.enc_addr;
      M_VEC:   nxt = RST_VEC;
      M_JMP:   nxt = bus.cr;
      M_INC:   nxt = inc;
      M_EC:    nxt = sts ? bus.enc_addr : bus.cr;
      M_VC:    nxt = sts ? RST_VEC : bus.cr;
      M_IV:    nxt = sts ? inc : RST_VEC;
      M_IC:    nxt = sts ? inc : bus.cr;
      M_CALL:  push = 1'b1;
      M_RET:   pop  = 1'b1;
      M_CCALL: push = sts;
      M_CRET:  pop  = sts;
      M_WAIT:  nxt = sts ? inc : state_q;
      default: nxt = inc;
    endcase
    // A call still jumps when the stack is full; a return on empty faults to the vector.
    if (push) nxt = bus.cr;
    if (pop)  nxt = top;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      sp_q    <= '0;
      stk_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.en) begin
      state_q <= nxt;
      if (push) begin
        if (full) ovf_q <= 1'b1;
        else begin
          stk_q[sp_q[IDX_W-1:0]] <= inc;
          sp_q                   <= sp_q + SP_W'(1);
        end
      end
      if (pop) begin
        if (empty) udf_q <= 1'b1;
        else       sp_q  <= sp_m1;
      end
    end
  end

  assign bus.state      = state_q;
  assign bus.next_state = nxt;
  assign bus.sp         = sp_q;
  assign bus.stk_ovf    = ovf_q;
  assign bus.stk_udf    = udf_q;
endmodule

// File: tb/tb_microseq_next_state.sv
// Randomised bench for microseq_next_state: queue-based reference model checked
// every rising edge, plus directed sequences with hand-computed expectations.
module tb_microseq_next_state;
  localparam int ADDR_W = 7, NCOND = 4, CSEL_W = 2, DEPTH = 4, RA = 1;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  logic checking = 1'b0;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  microseq_next_state_if #(.ADDR_W(ADDR_W), .NCOND(NCOND), .CSEL_W(CSEL_W),
                           .STACK_DEPTH(DEPTH)) bus ();

  microseq_next_state #(.ADDR_W(ADDR_W), .NCOND(NCOND), .CSEL_W(CSEL_W),
                        .STACK_DEPTH(DEPTH), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  // Reference model
  int m_state;
  int m_stk[$];
  int m_ovf, m_udf;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_stk.delete();
    m_ovf = 0;
    m_udf = 0;
  endtask

  // act: 0 none, 1 push return address, 2 pop
  function automatic void model_eval(output int nx, output int act);
    int sts, inc, sel;
    sel = int'(bus.s);
    sts = ((sel < NCOND) ? int'(bus.conds[sel]) : 0) ^ int'(bus.inv);
    inc = (m_state + 1) % (1 << ADDR_W);
    act = 0;
    case (int'(bus.n))
      0:  nx = bus.enc_addr;
      1:  nx = RA;
      2:  nx = bus.cr;
      3:  nx = inc;
      4:  nx = sts ? bus.enc_addr : bus.cr;
      5:  nx = sts ? RA : bus.cr;
      6:  nx = sts ? inc : RA;
      7:  nx = sts ? inc : bus.cr;
      8:  act = 1;
      9:  act = 2;
      10: act = sts ? 1 : 0;
      11: act = sts ? 2 : 0;
      12: nx = sts ? inc : m_state;
      default: nx = inc;
    endcase
    if (act == 0 && int'(bus.n) inside {8, 9, 10, 11}) nx = inc;
    if (act == 1) nx = bus.cr;
    if (act == 2) nx = (m_stk.size() == 0) ? RA : m_stk[$];
  endfunction

  task automatic model_apply();
    int nx, act;
    if (!bus.en) return;
    model_eval(nx, act);
    if (act == 1) begin
      if (m_stk.size() < DEPTH) m_stk.push_back((m_state + 1) % (1 << ADDR_W));
      else m_ovf = 1;
    end else if (act == 2) begin
      if (m_stk.size() == 0) m_udf = 1;
      else void'(m_stk.pop_back());
    end
    m_state = nx;
  endtask

  // Compare process: outputs are stable mid-cycle, away from the falling edge.
  always @(posedge clk) begin
    int nx, act;
    if (rst_n && checking) begin
      model_eval(nx, act);
      chk("state",      int'(bus.state),      m_state);
      chk("next_state", int'(bus.next_state), nx);
      chk("sp",         int'(bus.sp),         m_stk.size());
      chk("stk_ovf",    int'(bus.stk_ovf),    m_ovf);
      chk("stk_udf",    int'(bus.stk_udf),    m_udf);
    end
  end

  task automatic set_in(input logic e, input logic [3:0] nn, input logic [1:0] ss,
                        input logic iv, input logic [3:0] c,
                        input logic [6:0] ea, input logic [6:0] crv);
    bus.en = e; bus.n = nn; bus.s = ss; bus.inv = iv;
    bus.conds = c; bus.enc_addr = ea; bus.cr = crv;
  endtask

  task automatic step(input logic e, input logic [3:0] nn, input logic [1:0] ss,
                      input logic iv, input logic [3:0] c,
                      input logic [6:0] ea, input logic [6:0] crv);
    set_in(e, nn, ss, iv, c, ea, crv);
    @(negedge clk);
    model_apply();
    #1;
  endtask

  task automatic expect_st(input string name, input int st, input int spv);
    chk({name, ".state"}, int'(bus.state), st);
    chk({name, ".sp"},    int'(bus.sp),    spv);
  endtask

  initial begin
    int rets[4] = '{41, 31, 21, 11};
    set_in(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 7'd0, 7'd0);
    model_reset();
    #12;
    chk("rst.state", int'(bus.state), 0);
    chk("rst.sp",    int'(bus.sp), 0);
    chk("rst.ovf",   int'(bus.stk_ovf), 0);
    chk("rst.udf",   int'(bus.stk_udf), 0);
    rst_n = 1'b1;
    checking = 1'b1;

    // Incrementer, vector and wrap
    for (int i = 1; i <= 3; i++) begin
      step(1, 4'd3, 0, 0, 0, 0, 0);
      expect_st("inc", i, 0);
    end
    step(1, 4'd1, 0, 0, 0, 0, 0);   expect_st("vec", 1, 0);
    step(1, 4'd2, 0, 0, 0, 0, 127); expect_st("jmp127", 127, 0);
    step(1, 4'd3, 0, 0, 0, 0, 0);   expect_st("wrap", 0, 0);

    // Conditional encoder/CR select, combinational only
    set_in(0, 4'd4, 2'd0, 0, 4'b0000, 7'd9, 7'd8); #1;
    chk("m4.moc0", int'(bus.next_state), 8);
    set_in(0, 4'd4, 2'd0, 0, 4'b0001, 7'd9, 7'd8); #1;
    chk("m4.moc1", int'(bus.next_state), 9);
    set_in(0, 4'd4, 2'd0, 1, 4'b0001, 7'd9, 7'd8); #1;
    chk("m4.inv", int'(bus.next_state), 8);
    @(negedge clk); model_apply(); #1;

    // Single call/return
    step(1, 4'd2, 0, 0, 0, 0, 5);  expect_st("jmp5", 5, 0);
    step(1, 4'd8, 0, 0, 0, 0, 40); expect_st("call", 40, 1);
    step(1, 4'd9, 0, 0, 0, 0, 0);  expect_st("ret", 6, 0);
    chk("ret.ovf", int'(bus.stk_ovf), 0);
    chk("ret.udf", int'(bus.stk_udf), 0);

    // Nested calls past depth, then unwind past empty
    step(1, 4'd2, 0, 0, 0, 0, 10);
    for (int i = 0; i < 5; i++) step(1, 4'd8, 0, 0, 0, 0, 7'(20 + 10 * i));
    expect_st("call5", 60, 4);
    chk("call5.ovf", int'(bus.stk_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 4'd9, 0, 0, 0, 0, 0);
      expect_st("unwind", rets[i], 3 - i);
    end
    step(1, 4'd9, 0, 0, 0, 0, 0); expect_st("udf", 1, 0);
    chk("udf.flag", int'(bus.stk_udf), 1);

    // Wait on dmoc, then stall
    step(1, 4'd2, 0, 0, 0, 0, 20);
    for (int i = 0; i < 3; i++) begin
      step(1, 4'd12, 2'd2, 0, 4'b0000, 0, 0);
      expect_st("wait", 20, 0);
    end
    step(1, 4'd12, 2'd2, 0, 4'b0100, 0, 0); expect_st("wait.go", 21, 0);
    step(0, 4'd3, 0, 0, 0, 0, 0);           expect_st("stall", 21, 0);

    // Asynchronous reset in the middle of a call chain
    step(1, 4'd2, 0, 0, 0, 0, 5);
    step(1, 4'd8, 0, 0, 0, 0, 40);
    step(1, 4'd8, 0, 0, 0, 0, 50); expect_st("depth2", 50, 2);
    rst_n = 1'b0; model_reset(); #1;
    chk("arst.state", int'(bus.state), 0);
    chk("arst.sp",    int'(bus.sp), 0);
    chk("arst.ovf",   int'(bus.stk_ovf), 0);
    chk("arst.udf",   int'(bus.stk_udf), 0);
    rst_n = 1'b1;

    // Random traffic, occasional mid-cycle reset
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0; model_reset(); #1; rst_n = 1'b1;
      end
      step(logic'($urandom_range(0, 7) != 0), 4'($urandom_range(0, 15)),
           2'($urandom), 1'($urandom), 4'($urandom), 7'($urandom), 7'($urandom));
    end

    checking = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/microseq_next_state.md
Name: microseq_next_state

Overview:
- Parametrised microprogram sequencer for the control unit. Registers the current control-store state and computes the next one.
- Sources for the next state: opcode encoder, reset vector, microinstruction CR field, incrementer, or an internal return-address stack.
- Generalises address width, condition count and branch modes. Adds micro-subroutine call/return, wait-for-condition hold, stall enable and stack error flags.

Parameters:
- ADDR_W, 7, control-store address width.
- NCOND, 4, number of condition inputs (bit 0 moc, 1 cond, 2 dmoc, 3 spare).
- CSEL_W, 2, condition-select width; must satisfy 2**CSEL_W >= NCOND.
- STACK_DEPTH, 4, return-address stack entries (>=1).
- RESET_ADDR, 1, hard-coded reset/fault vector.

Ports:
- clk  in  1  system clock; all registers update on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  advance enable; 0 = stall, no register changes.
- n  in  4  next-state mode from the microinstruction.
- s  in  CSEL_W  condition select.
- inv  in  1  invert the selected condition.
- conds  in  NCOND  condition inputs.
- enc_addr  in  ADDR_W  opcode encoder target.
- cr  in  ADDR_W  microinstruction target (CR) field.
- state  out  ADDR_W  current state, registered.
- next_state  out  ADDR_W  combinational next state.
- sp  out  clog2(STACK_DEPTH+1)  stack occupancy.
- stk_ovf  out  1  sticky overflow flag.
- stk_udf  out  1  sticky underflow flag.

Behaviour:
- Reset (asynchronous, any time including mid-call): state=0, sp=0, stk_ovf=0, stk_udf=0, all stack entries=0.
- sts = (s < NCOND ? conds[s] : 0) XOR inv. Purely combinational.
- inc = state+1, modulo 2**ADDR_W; 2**ADDR_W-1 wraps to 0.
- Mode table (n -> next_state, stack action):
  - 0 ENC: enc_addr.
  - 1 VEC: RESET_ADDR.
  - 2 JMP: cr.
  - 3 INC: inc.
  - 4: sts ? enc_addr : cr.
  - 5: sts ? RESET_ADDR : cr.
  - 6: sts ? inc : RESET_ADDR.
  - 7: sts ? inc : cr.
  - 8 CALL: cr; push inc.
  - 9 RET: top of stack; pop.
  - 10 CCALL: sts ? CALL : INC.
  - 11 CRET: sts ? RET : INC.
  - 12 WAIT: sts ? inc : state (hold; models wait for moc/dmoc).
  - 13-15 reserved: behave as INC.
- next_state is valid combinationally in the same cycle. state <= next_state on each falling edge with en=1. Latency from inputs to state is one edge.
- Stack is LIFO. Push writes entry[sp] and sets sp+1. Pop reads entry[sp-1] and sets sp-1. Actions happen only on an enabled edge.
- Push when sp==STACK_DEPTH: entry discarded, sp unchanged, stk_ovf set, next_state still cr.
- Pop when sp==0: next_state=RESET_ADDR, sp stays 0, stk_udf set.
- Both flags are sticky until reset.
- At most one stack action per cycle; no simultaneous push/pop exists.
- en=0: state, sp, stack and flags hold. next_state still reflects current inputs.
- No latches: every mode drives next_state fully.

Test Plan:
- Reset, then n=3 with en=1 for 3 edges -> state 0,1,2,3. Then n=1 -> state 1. Set state 127, n=3 -> state wraps to 0.
- n=4, s=0, inv=0, enc_addr=9, cr=8: moc=0 -> next_state 8; moc=1 -> 9; moc=1 with inv=1 -> 8.
- From state 5, n=8, cr=40 -> state 40, sp=1. Then n=9 -> state 6, sp=0, no flags set.
- Nested CALLs: 5 CALLs with STACK_DEPTH=4 -> sp=4, stk_ovf=1 after the 5th. Then 4 RETs return the first four pushed addresses in reverse order. A 5th RET -> state 1, stk_udf=1.
- n=12, s=2, dmoc=0 for 3 edges -> state holds at 20. dmoc=1 -> state 21. en=0 with n=3 -> state holds.
- During CALL depth 2, assert rst_n low between edges -> state, sp and flags read 0 immediately with no clock edge.
